// File: rtl/demux_buf_1to4.sv
// demux_buf_1to4: registered 1-to-4 demultiplexer with one holding slot per channel.
// Each input word is steered by in_sel into one of four output registers.
// Every channel has its own valid/ready handshake and drains independently.
// Optional build macro DEMUX_CNT_EN adds four CW-bit load counters on the cnt port.
//
// Per-channel state (out_valid[i] is the state bit):
//   state | meaning
//   EMPTY | slot holds no word; out_ready[i] ignored
//   FULL  | slot holds a word awaiting drain; out_data[i] stable until next load
module demux_buf_1to4 #(
    parameter int WIDTH = 8,
    parameter int CW    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [1:0]         in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [4*WIDTH-1:0] out_data,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready
`ifdef DEMUX_CNT_EN
    ,
    output logic [4*CW-1:0]    cnt
`endif
);

    logic [3:0]       full_q;
    logic [3:0]       full_d;
    logic [3:0]       load;
    logic [3:0]       drain;
    logic [WIDTH-1:0] data_q [4];

    // State register: one full/empty bit per channel, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 4'b0000;
        end else begin
            full_q <= full_d;
        end
    end

    // Next-state logic: a load fills the slot, a drain without a load empties it.
    always_comb begin
        load   = 4'b0000;
        drain  = 4'b0000;
        full_d = full_q;
        for (int i = 0; i < 4; i++) begin
            load[i]   = in_valid & in_ready & (in_sel == 2'(i));
            drain[i]  = full_q[i] & out_ready[i];
            full_d[i] = load[i] | (full_q[i] & ~drain[i]);
        end
    end

    // Output logic: ready follows the currently selected channel; reset blocks accepts.
    always_comb begin
        out_valid = full_q;
        in_ready  = rst_n & (~full_q[in_sel] | out_ready[in_sel]);
        out_data  = '0;
        for (int i = 0; i < 4; i++) begin
            out_data[i*WIDTH +: WIDTH] = data_q[i];
        end
    end

    // Holding registers: data only changes when its channel is loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (load[i]) begin
                    data_q[i] <= in_data;
                end
            end
        end
    end

`ifdef DEMUX_CNT_EN
    logic [CW-1:0] cnt_q [4];

    // Load counters: one per channel, wrap naturally, unaffected by drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (load[i]) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Flatten the counters onto the cnt port.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < 4; i++) begin
            cnt[i*CW +: CW] = cnt_q[i];
        end
    end
`else
    // Without counters CW sizes nothing; this keeps it referenced.
    if (CW < 1) begin : g_cw_unused
    end
`endif

endmodule

// File: tb/tb_demux_buf_1to4.sv
// tb_demux_buf_1to4: directed self-checking bench for demux_buf_1to4.
// Build with DEMUX_CNT_EN defined to also exercise the load counters (CW=4).
module tb_demux_buf_1to4;

    localparam int WIDTH = 8;
    localparam int CW    = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [WIDTH-1:0]   in_data;
    logic [1:0]         in_sel;
    logic               in_valid;
    logic               in_ready;
    logic [4*WIDTH-1:0] out_data;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;
`ifdef DEMUX_CNT_EN
    logic [4*CW-1:0]    cnt;
`endif

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] q [4][$];
    logic [5:0]       sv;
    logic             acc;
    int               waitc;
    logic [WIDTH-1:0] exp_w;

    demux_buf_1to4 #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef DEMUX_CNT_EN
        ,
        .cnt       (cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] ch(input int i);
        return out_data[i*WIDTH +: WIDTH];
    endfunction

    // Scoreboard observation before an edge: valids match queue occupancy,
    // drains deliver the oldest queued word, in_ready matches the handshake rule.
    task automatic observe();
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("sweep_valid_ch%0d", c), 64'(out_valid[c]), 64'(q[c].size() != 0));
            if (out_valid[c] && out_ready[c] && q[c].size() != 0) begin
                exp_w = q[c].pop_front();
                chk($sformatf("sweep_data_ch%0d", c), 64'(ch(c)), 64'(exp_w));
            end
        end
        if (in_valid) begin
            chk("sweep_in_ready", 64'(in_ready),
                64'(!(q[in_sel].size() != 0) || out_ready[in_sel]));
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = '0;
        in_sel    = 2'd0;
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'h0);
        chk("reset_out_data", 64'(out_data), 64'h0);
        chk("reset_in_ready", 64'(in_ready), 64'h0);
        step();
        rst_n = 1'b1;
        #1;
        chk("release_in_ready", 64'(in_ready), 64'h1);

        // Basic routing
        out_ready = 4'b1111;
        for (int s = 0; s < 4; s++) begin
            in_sel   = 2'(s);
            in_data  = 8'hA0 + 8'(s);
            in_valid = 1'b1;
            #1;
            chk("route_in_ready", 64'(in_ready), 64'h1);
            step();
            in_valid = 1'b0;
            #1;
            chk($sformatf("route_valid_sel%0d", s), 64'(out_valid), 64'(4'b0001 << s));
            chk($sformatf("route_data_sel%0d", s), 64'(ch(s)), 64'(8'hA0 + 8'(s)));
            step();
            chk("route_drained", 64'(out_valid), 64'h0);
        end

        // Backpressure
        out_ready = 4'b1101;
        in_sel    = 2'd1;
        in_data   = 8'h11;
        in_valid  = 1'b1;
        step();
        in_data = 8'h22;
        #1;
        chk("bp_stall_ready", 64'(in_ready), 64'h0);
        step();
        chk("bp_ch1_valid", 64'(out_valid), 64'b0010);
        chk("bp_ch1_hold", 64'(ch(1)), 64'h11);
        in_sel  = 2'd3;
        in_data = 8'h33;
        #1;
        chk("bp_ch3_ready", 64'(in_ready), 64'h1);
        step();
        chk("bp_ch3_valid", 64'(out_valid), 64'b1010);
        chk("bp_ch3_data", 64'(ch(3)), 64'h33);
        in_sel    = 2'd1;
        in_data   = 8'h22;
        out_ready = 4'b1111;
        #1;
        chk("bp_release_ready", 64'(in_ready), 64'h1);
        step();
        in_valid = 1'b0;
        chk("bp_swap_valid", 64'(out_valid), 64'b0010);
        chk("bp_swap_data", 64'(ch(1)), 64'h22);
        step();
        chk("bp_empty", 64'(out_valid), 64'h0);

        // Streaming to channel 0
        in_sel   = 2'd0;
        in_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            in_data = 8'(k);
            #1;
            chk("stream_in_ready", 64'(in_ready), 64'h1);
            step();
            chk("stream_valid", 64'(out_valid), 64'b0001);
            chk("stream_data", 64'(ch(0)), 64'(k));
        end
        in_valid = 1'b0;
        step();
        chk("stream_end", 64'(out_valid), 64'h0);

        // Select sweep with random backpressure
        for (int i = 0; i < 64; i++) begin
            sv       = 6'(i);
            in_sel   = sv[1:0];
            in_data  = {4'h0, sv[5:2]};
            in_valid = 1'b1;
            acc      = 1'b0;
            waitc    = 0;
            while (!acc && waitc < 40) begin
                out_ready = 4'($urandom_range(0, 15));
                #1;
                observe();
                acc = in_ready;
                step();
                if (acc) q[in_sel].push_back(in_data);
                waitc++;
            end
            chk("sweep_accept_timeout", 64'(acc), 64'h1);
        end
        in_valid  = 1'b0;
        out_ready = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            #1;
            observe();
            step();
        end
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("sweep_left_ch%0d", c), 64'(q[c].size()), 64'h0);
        end
        chk("sweep_all_empty", 64'(out_valid), 64'h0);

        // Mid-stream asynchronous reset with channel 2 full
        out_ready = 4'b1011;
        in_sel    = 2'd2;
        in_data   = 8'h5A;
        in_valid  = 1'b1;
        step();
        in_data = 8'h6B;
        #1;
        chk("mid_ch2_valid", 64'(out_valid), 64'b0100);
        chk("mid_ch2_data", 64'(ch(2)), 64'h5A);
        chk("mid_ch2_stall", 64'(in_ready), 64'h0);
        out_ready = 4'b1111;
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_reset_valid", 64'(out_valid), 64'h0);
        chk("mid_reset_data", 64'(out_data), 64'h0);
        chk("mid_reset_ready", 64'(in_ready), 64'h0);
        in_valid = 1'b0;
        step();
        chk("mid_reset_hold", 64'(out_valid), 64'h0);
        rst_n = 1'b1;
        #1;
        chk("mid_release_ready", 64'(in_ready), 64'h1);
        step();
        chk("mid_release_valid", 64'(out_valid), 64'h0);

`ifdef DEMUX_CNT_EN
        chk("cnt_after_reset", 64'(cnt), 64'h0);
        out_ready = 4'b1111;
        in_sel    = 2'd2;
        in_valid  = 1'b1;
        for (int k = 0; k < 16; k++) begin
            in_data = 8'(k);
            step();
        end
        #1;
        chk("cnt_wrap16", 64'(cnt), 64'h0);
        in_valid = 1'b0;
        step();
        out_ready = 4'b1011;
        in_data   = 8'h77;
        in_valid  = 1'b1;
        step();
        in_data = 8'h88;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("cnt_stall_ready", 64'(in_ready), 64'h0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 4'b1111;
        step();
        step();
        chk("cnt_17_loads", 64'(cnt), 64'h0100);
        chk("cnt_ch2_last", 64'(ch(2)), 64'h77);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
